// File: rtl/lif_pkg.sv
// Shared definitions for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

  // Membrane potential width and its saturation ceiling
  localparam int POT_W = 8;
  localparam logic [POT_W-1:0] POT_SAT = 8'd255;

  // Width of the intermediate update sum; wide enough for 255 + 255
  localparam int SUM_W = 10;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Refractory counter width; a disabled refractory period still keeps one bit
  function automatic int refrac_width(input int ticks);
    int w;
    w = (ticks > 0) ? $clog2(ticks + 1) : 1;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/lif_step.sv
// Combinational leaky-integrate-and-fire update for a single neuron.
module lif_step
  import lif_pkg::*;
#(
  parameter int THRESHOLD    = 128,
  parameter int LEAK_SHIFT   = 2,
  parameter int REFRAC_TICKS = 2,
  parameter int REFRAC_W     = refrac_width(REFRAC_TICKS)
) (
  input  logic [POT_W-1:0]    pot,
  input  logic [POT_W-1:0]    cur,
  input  logic [REFRAC_W-1:0] refrac,
  output logic [POT_W-1:0]    next_pot,
  output logic [REFRAC_W-1:0] next_refrac,
  output logic                spike
);

  localparam logic [SUM_W-1:0]    THR_EXT    = SUM_W'(THRESHOLD);
  localparam logic [REFRAC_W-1:0] REFRAC_RLD = REFRAC_W'(REFRAC_TICKS);

  // Clamp the widened sum back into the potential range
  function automatic logic [POT_W-1:0] sat_pot(input logic [SUM_W-1:0] n);
    if (n > SUM_W'(POT_SAT)) begin
      return POT_SAT;
    end
    return n[POT_W-1:0];
  endfunction

  logic [SUM_W-1:0] leak;
  logic [SUM_W-1:0] sum;
  logic [POT_W-1:0] sat;

  // Leak, integrate and saturate; a refractory neuron is clamped to zero
  always_comb begin
    leak        = {2'b00, pot >> LEAK_SHIFT};
    sum         = {2'b00, pot} - leak + {2'b00, cur};
    sat         = sat_pot(sum);
    next_pot    = '0;
    next_refrac = '0;
    spike       = 1'b0;
    if (refrac != '0) begin
      next_refrac = refrac - 1'b1;
    end else if ({2'b00, sat} >= THR_EXT) begin
      spike       = 1'b1;
      next_refrac = REFRAC_RLD;
    end else begin
      next_pot = sat;
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps NUM_NEURONS neurons through one shared LIF update per external tick.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS  = 4,
  parameter int THRESHOLD    = 128,
  parameter int LEAK_SHIFT   = 2,
  parameter int REFRAC_TICKS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic [NUM_NEURONS*8-1:0]       current_in,
  input  logic [$clog2(NUM_NEURONS)-1:0] rd_sel,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_NEURONS-1:0]         spike_vec,
  output logic [POT_W-1:0]               rd_state,
  output logic                           overrun
);

  localparam int IW = $clog2(NUM_NEURONS);
  localparam int RW = refrac_width(REFRAC_TICKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [POT_W-1:0]       pot_mem    [NUM_NEURONS];
  logic [RW-1:0]          refrac_mem [NUM_NEURONS];
  logic [POT_W-1:0]       cur_lat    [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] pending;

  // Operand registers filled in LOAD, consumed in WRITE
  logic [POT_W-1:0]       pot_p0;
  logic [POT_W-1:0]       cur_p0;
  logic [RW-1:0]          refrac_p0;

  // Update results available combinationally during WRITE
  logic [POT_W-1:0]       pot_p1;
  logic [RW-1:0]          refrac_p1;
  logic                   spike_p1;

  lif_step #(
    .THRESHOLD   (THRESHOLD),
    .LEAK_SHIFT  (LEAK_SHIFT),
    .REFRAC_TICKS(REFRAC_TICKS),
    .REFRAC_W    (RW)
  ) u_step (
    .pot        (pot_p0),
    .cur        (cur_p0),
    .refrac     (refrac_p0),
    .next_pot   (pot_p1),
    .next_refrac(refrac_p1),
    .spike      (spike_p1)
  );

  assign busy = (state != IDLE);

  // Sweep FSM: latch currents, load/write each neuron, publish spikes
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= '0;
      spike_vec <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      pot_p0    <= '0;
      cur_p0    <= '0;
      refrac_p0 <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot_mem[i]    <= '0;
        refrac_mem[i] <= '0;
        cur_lat[i]    <= '0;
      end
    end else begin
      // A tick outside IDLE is dropped but remembered
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (tick) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
              cur_lat[i] <= current_in[8*i +: 8];
            end
            idx     <= '0;
            pending <= '0;
            state   <= LOAD;
          end
        end
        // ---- stage p0: fetch operands of neuron idx ----
        LOAD: begin
          pot_p0    <= pot_mem[idx];
          refrac_p0 <= refrac_mem[idx];
          cur_p0    <= cur_lat[idx];
          state     <= WRITE;
        end
        // ---- stage p1: write back the shared update result ----
        WRITE: begin
          pot_mem[idx]    <= pot_p1;
          refrac_mem[idx] <= refrac_p1;
          if (spike_p1) begin
            pending[idx] <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            spike_vec <= pending | (NUM_NEURONS'(spike_p1) << idx);
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Registered potential readout, one cycle behind rd_sel
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= '0;
    end else begin
      rd_state <= pot_mem[rd_sel];
    end
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Scoreboard bench for lif_scheduler: two instances (refractory 2 and disabled).
module tb_lif_scheduler;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic [N*8-1:0]   current_in;
  logic [1:0]       rd_sel;

  logic             busy_a, done_a, overrun_a;
  logic [N-1:0]     spike_a;
  logic [7:0]       rd_a;
  logic             busy_b, done_b, overrun_b;
  logic [N-1:0]     spike_b;
  logic [7:0]       rd_b;

  always #5 clk = ~clk;

  lif_scheduler #(.NUM_NEURONS(N), .THRESHOLD(128), .LEAK_SHIFT(2), .REFRAC_TICKS(2)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .current_in(current_in), .rd_sel(rd_sel),
    .busy(busy_a), .done(done_a), .spike_vec(spike_a), .rd_state(rd_a), .overrun(overrun_a)
  );

  lif_scheduler #(.NUM_NEURONS(N), .THRESHOLD(128), .LEAK_SHIFT(2), .REFRAC_TICKS(0)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .current_in(current_in), .rd_sel(rd_sel),
    .busy(busy_b), .done(done_b), .spike_vec(spike_b), .rd_state(rd_b), .overrun(overrun_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected spike vectors, one entry per accepted sweep
  logic [N-1:0] q_a[$];
  logic [N-1:0] q_b[$];
  logic [N-1:0] mon_a, mon_b;
  logic [N-1:0] last_a, last_b;

  // Reference neuron state
  int pot_a[N], ref_a[N], pot_b[N], ref_b[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural LIF rule for one neuron and one tick
  function automatic void model_neuron(inout int p, inout int r, input int cur, input int rt,
                                       output bit spk);
    int n;
    spk = 1'b0;
    if (r > 0) begin
      p = 0;
      r = r - 1;
    end else begin
      n = p - (p / 4) + cur;
      if (n > 255) n = 255;
      if (n >= 128) begin
        spk = 1'b1;
        p   = 0;
        r   = rt;
      end else begin
        p = n;
      end
    end
  endfunction

  // Apply one tick to both models and queue the expected spike vectors
  task automatic model_tick(input logic [N*8-1:0] cur);
    bit s;
    last_a = '0;
    last_b = '0;
    for (int i = 0; i < N; i++) begin
      model_neuron(pot_a[i], ref_a[i], int'(cur[8*i +: 8]), 2, s);
      last_a[i] = s;
      model_neuron(pot_b[i], ref_b[i], int'(cur[8*i +: 8]), 0, s);
      last_b[i] = s;
    end
    q_a.push_back(last_a);
    q_b.push_back(last_b);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      pot_a[i] = 0; ref_a[i] = 0; pot_b[i] = 0; ref_b[i] = 0;
    end
  endtask

  // Monitor: compare published spikes whenever a done pulse appears
  always @(negedge clk) begin
    if (done_a) begin
      if (q_a.size() == 0) begin
        check("unexpected_done_a", 32'd1, 32'd0);
      end else begin
        mon_a = q_a.pop_front();
        check("spike_vec_a", spike_a, mon_a);
      end
    end
    if (done_b) begin
      if (q_b.size() == 0) begin
        check("unexpected_done_b", 32'd1, 32'd0);
      end else begin
        mon_b = q_b.pop_front();
        check("spike_vec_b", spike_b, mon_b);
      end
    end
  end

  // Wait for done with a cycle budget; returns the edge number it appeared after
  task automatic wait_done(input int start, output int edge_no);
    edge_no = start;
    while (!done_a && edge_no < 40) begin
      @(posedge clk); #1;
      edge_no++;
    end
  endtask

  // One full sweep with timing checks
  task automatic sweep(input logic [N*8-1:0] cur);
    int e;
    @(negedge clk);
    current_in = cur;
    tick       = 1'b1;
    model_tick(cur);
    @(posedge clk); #1;
    tick = 1'b0;
    check("busy_after_accept", busy_a, 1'b1);
    wait_done(0, e);
    check("done_latency", e, 8);
    @(posedge clk); #1;
    check("busy_after_done", busy_a, 1'b0);
    check("done_one_cycle", done_a, 1'b0);
    check("spike_hold_a", spike_a, last_a);
    check("spike_hold_b", spike_b, last_b);
  endtask

  // Read every stored potential through rd_sel
  task automatic check_pots();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_sel = 2'(i);
      @(posedge clk); #1;
      check("rd_state_a", rd_a, pot_a[i]);
      check("rd_state_b", rd_b, pot_b[i]);
    end
  endtask

  initial begin
    logic [N*8-1:0] cur;
    int e;
    reset = 1'b1; tick = 1'b0; current_in = '0; rd_sel = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", busy_a, 1'b0);
    check("reset_done", done_a, 1'b0);
    check("reset_spike", spike_a, 4'b0);
    check("reset_rd_state", rd_a, 8'd0);
    check("reset_overrun", overrun_a, 1'b0);

    // Integrate to spike, then refractory behaviour with current held
    for (int t = 0; t < 6; t++) begin
      sweep({8'd0, 8'd0, 8'd0, 8'd64});
      check_pots();
    end
    check("no_overrun_yet", overrun_a, 1'b0);

    // Large currents exercise saturation
    sweep({8'd0, 8'd0, 8'd100, 8'd0});
    check_pots();
    sweep({8'd255, 8'd0, 8'd255, 8'd0});
    check_pots();

    // Overrun and current latching
    cur = {8'd30, 8'd20, 8'd10, 8'd40};
    @(negedge clk);
    current_in = cur;
    tick = 1'b1;
    model_tick(cur);
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    check("overrun_set_a", overrun_a, 1'b1);
    check("overrun_set_b", overrun_b, 1'b1);
    current_in = {8'd250, 8'd250, 8'd250, 8'd250};
    wait_done(3, e);
    check("done_latency_overrun", e, 8);
    @(posedge clk); #1;
    check("overrun_sticky", overrun_a, 1'b1);
    check_pots();

    // Reset in the middle of a sweep discards it
    @(negedge clk);
    current_in = {8'd90, 8'd90, 8'd90, 8'd90};
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    check("midreset_busy", busy_a, 1'b0);
    check("midreset_spike", spike_a, 4'b0);
    check("midreset_overrun_a", overrun_a, 1'b0);
    check("midreset_overrun_b", overrun_b, 1'b0);
    check("midreset_done", done_a, 1'b0);
    repeat (12) @(posedge clk);
    check_pots();
    sweep({8'd0, 8'd0, 8'd0, 8'd64});
    check_pots();

    // Randomized sweeps against the reference model
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        cur[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 70));
      end
      sweep(cur);
      check_pots();
    end

    repeat (4) @(posedge clk);
    check("queue_drained_a", q_a.size(), 0);
    check("queue_drained_b", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
